// File: rtl/uart_tx.sv
// 8N1 UART transmitter for the command link: sends {dado, instrucao} LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for enviar
// START  | start bit (0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the latched byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (1)
// DONE   | one-cycle feito pulse
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] instrucao,
  input  logic [3:0] dado,
  input  logic       enviar,
  output logic       tx,
  output logic       ocupado,
  output logic       feito,
  output logic [7:0] led
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

  state_t          state, state_nxt;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            bit_end;
  logic            load;

  assign bit_end = (baud_cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // tx is decoded from state so an async reset forces the line high at once
  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    ocupado   = 1'b0;
    feito     = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (enviar) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx      = 1'b0;
        ocupado = 1'b1;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx      = shreg[0];
        ocupado = 1'b1;
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx      = ^led;
        ocupado = 1'b1;
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        ocupado = 1'b1;
        if (bit_end) state_nxt = DONE;
      end
      DONE: begin
        feito     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg    <= 8'h00;
      led      <= 8'h00;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
    end else if (load) begin
      shreg    <= {dado, instrucao};
      led      <= {dado, instrucao};
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
    end else if (ocupado) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (state == DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end else begin
      baud_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4; honours UART_TX_PARITY_EN.
module tb_uart_tx;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enviar = 1'b0;
  logic [3:0] instrucao = 4'd0;
  logic [3:0] dado = 4'd0;
  logic       tx, ocupado, feito;
  logic [7:0] led;

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clock(clock), .reset(reset), .instrucao(instrucao), .dado(dado),
    .enviar(enviar), .tx(tx), .ocupado(ocupado), .feito(feito), .led(led)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] ins;
    logic [3:0] dat;
    logic [7:0] led_exp;
  } vec_t;
  vec_t vecs[5];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: line level j cycles into the frame, from the frame bit list.
  function automatic logic expected_tx(input logic [7:0] b, input int j);
    int n;
    n = j / C;
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
`ifdef UART_TX_PARITY_EN
    if (n == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called right after the start edge; checks every frame cycle plus the feito cycle.
  task automatic check_frame(input logic [7:0] b, input int poke);
    for (int j = 0; j <= NB * C; j++) begin
      @(negedge clock);
      if (j < NB * C) begin
        chk1("tx", tx, expected_tx(b, j));
        chk1("ocupado", ocupado, 1'b1);
        chk1("feito_early", feito, 1'b0);
      end else begin
        chk1("done_tx", tx, 1'b1);
        chk1("done_ocupado", ocupado, 1'b0);
        chk1("feito", feito, 1'b1);
      end
      if (poke >= 0 && j == poke) begin
        instrucao = 4'd1;
        dado      = 4'hF;
        enviar    = 1'b1;
      end
      if (poke >= 0 && j == poke + 1) enviar = 1'b0;
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk1("idle_tx", tx, 1'b1);
      chk1("idle_ocupado", ocupado, 1'b0);
      chk1("idle_feito", feito, 1'b0);
    end
  endtask

  task automatic send(input logic [3:0] ins, input logic [3:0] dat,
                      input logic [7:0] exp_byte, input int poke);
    @(negedge clock);
    instrucao = ins;
    dado      = dat;
    enviar    = 1'b1;
    @(posedge clock);
    #1 enviar = 1'b0;
    chk8("led_latch", led, exp_byte);
    check_frame(exp_byte, poke);
    check_idle(3);
  endtask

  initial begin
    vecs[0] = '{ins: 4'h2, dat: 4'hA, led_exp: 8'hA2};
    vecs[1] = '{ins: 4'h4, dat: 4'h0, led_exp: 8'h04};
    vecs[2] = '{ins: 4'h1, dat: 4'h0, led_exp: 8'h01};
    vecs[3] = '{ins: 4'hF, dat: 4'hF, led_exp: 8'hFF};
    vecs[4] = '{ins: 4'h0, dat: 4'h5, led_exp: 8'h50};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk1("reset_tx", tx, 1'b1);
    chk8("reset_led", led, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk1("rst_idle_tx", tx, 1'b1);
      chk1("rst_idle_ocupado", ocupado, 1'b0);
      chk1("rst_idle_feito", feito, 1'b0);
      chk8("rst_idle_led", led, 8'h00);
    end

    for (int v = 0; v < 5; v++)
      send(vecs[v].ins, vecs[v].dat, vecs[v].led_exp, -1);

    // inputs and enviar changed mid-frame must not disturb the byte or retrigger
    send(4'h4, 4'h0, 8'h04, 10);
    chk8("led_hold", led, 8'h04);
    check_idle(8);

    // enviar held: back-to-back frames with a two-cycle gap
    @(negedge clock);
    instrucao = 4'h1;
    dado      = 4'h0;
    enviar    = 1'b1;
    @(posedge clock);
    #1 chk8("b2b_led", led, 8'h01);
    check_frame(8'h01, -1);
    @(negedge clock);
    chk1("gap_tx", tx, 1'b1);
    chk1("gap_ocupado", ocupado, 1'b0);
    @(posedge clock);
    #1 enviar = 1'b0;
    check_frame(8'h01, -1);
    check_idle(6);

    // reset during data bit 3 of 8'hA2 (bit 3 is 0)
    @(negedge clock);
    instrucao = 4'h2;
    dado      = 4'hA;
    enviar    = 1'b1;
    @(posedge clock);
    #1 enviar = 1'b0;
    repeat (18) @(negedge clock);
    chk1("pre_reset_tx", tx, 1'b0);
    chk1("pre_reset_ocupado", ocupado, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk1("async_reset_tx", tx, 1'b1);
    chk1("async_reset_ocupado", ocupado, 1'b0);
    chk1("async_reset_feito", feito, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk1("in_reset_feito", feito, 1'b0);
      chk8("in_reset_led", led, 8'h00);
    end
    reset = 1'b0;
    check_idle(5);
    send(4'h2, 4'hA, 8'hA2, -1);

    for (int r = 0; r < 20; r++) begin
      logic [3:0] ri, rd;
      ri = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15));
      send(ri, rd, {rd, ri}, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the command link: latches one 4-bit instruction and one 4-bit data nibble, then shifts them out as a single 8N1 UART frame on one line. The block sits on the sending board and is the far end of the receiver that decodes `instrucao`/`dado` (clear / load / show). A host FSM or debounced push-button drives `enviar`; `ocupado` and `feito` report frame progress.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud). Legal range is ≥ 2.

Ports:
- `clock`, input, 1: single system clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `instrucao`, input, 4: instruction nibble (1 = clear, 2 = load, 4 = show). Only sampled at frame start.
- `dado`, input, 4: data nibble. Only sampled at frame start.
- `enviar`, input, 1: send request. Level-sensitive; sampled only in IDLE.
- `tx`, output, 1: serial line. Idle is high.
- `ocupado`, output, 1: high from the first cycle of the start bit through the last cycle of the stop bit.
- `feito`, output, 1: one-cycle pulse when the frame completes.
- `led`, output, 8: last latched frame byte `{dado, instrucao}`.

## Operation

- Frame byte is `{dado, instrucao}`. It is sent LSB first, so `instrucao[0]` goes out first and `dado[3]` goes out last.
- Frame format: start bit (0), 8 data bits, optional parity bit (see Configuration), stop bit (1).
- States: IDLE, START, DATA, PARITY (present only when the macro is defined), STOP, DONE.
- IDLE: `tx`=1 and `ocupado`=0.
  - If `enviar`=1 at a rising edge, latch the byte into the shift register and into `led`, clear the bit counter and baud counter, and go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: `tx` = shift-register bit 0 for `CLKS_PER_BIT` cycles, then shift right and increment a 3-bit index.
  - After index 7 completes, go to PARITY (if enabled) or STOP.
- PARITY: `tx` = XOR of the latched byte for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to DONE.
- DONE: one cycle with `feito`=1, `ocupado`=0, `tx`=1, then go to IDLE.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts from 0 to `CLKS_PER_BIT-1` and wraps to 0 at each bit boundary.
- `enviar` and input changes during any non-IDLE state are ignored. The latched byte cannot change mid-frame.
- If `enviar` is held high continuously, a new frame starts each time IDLE is re-entered, so frames are separated by exactly the DONE and IDLE cycles.

## Timing

- Reset values: `tx`=1, `ocupado`=0, `feito`=0, `led`=8'h00, state=IDLE, all counters=0, shift register=0.
- Reset asserted mid-frame: `tx` returns high immediately, asynchronously. No `feito` pulse is produced for the aborted frame.
- Edge 0 samples `enviar`=1 in IDLE. From the cycle after edge 0, `tx`=0 and `ocupado`=1.
- Data bit k occupies cycles `(1+k)·CLKS_PER_BIT` through `(2+k)·CLKS_PER_BIT − 1`, counted from the start-bit cycle.
- Frame length (`ocupado` high) is 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- `feito` is high in the single cycle immediately after the last stop-bit cycle.
- Minimum gap between stop bit end and the next start bit is 2 cycles (DONE + IDLE).
- `led` updates on the same edge that latches the frame. It holds its value until the next latch or a reset.

## Configuration

- `UART_TX_PARITY_EN`, when defined:
  - The PARITY state exists.
  - An even-parity bit (XOR of the 8 data bits) is sent between data bit 7 and the stop bit.
  - The frame is 11 bits.
- Without `UART_TX_PARITY_EN`:
  - No PARITY state.
  - DATA goes directly to STOP.
  - Plain 8N1 frame of 10 bits.

## Test plan

All scenarios use `CLKS_PER_BIT`=4.
- Reset release with `enviar`=0 for 20 cycles → `tx`=1, `ocupado`=0, `feito`=0, `led`=0 throughout.
- `instrucao`=2, `dado`=4'hA, `enviar` pulsed 1 cycle:
  - `led`=8'hA2.
  - Line shows, every 4 cycles: 0, 0,1,0,0,0,1,0,1, 1.
  - `ocupado` is high for 40 cycles, then one `feito` pulse.
- Same stimulus with `UART_TX_PARITY_EN` → parity bit 1 (three ones) before the stop bit, and `ocupado` is high for 44 cycles.
- `instrucao`=4, `dado`=0 sent, with inputs changed to 1/4'hF and `enviar` re-pulsed mid-frame → serial byte remains 8'h04, and no second frame follows.
- `enviar` held high with `instrucao`=1, `dado`=0 → back-to-back 8'h01 frames, 2-cycle idle gap between the stop bit and the next start bit.
- `reset` asserted during data bit 3 → `tx`=1 and `ocupado`=0 immediately, with no `feito`. After release, `enviar` starts a clean full frame.
